// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types: word, RAM status and arbiter state encodings
package cpu_types_pkg;

    localparam int WORD_WIDTH = 32;

    typedef logic [WORD_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IBUSY = 3'd1,
        DBUSY = 3'd2,
        IHIT  = 3'd3,
        DHIT  = 3'd4
    } arb_state_t;

    function automatic logic is_busy(arb_state_t s);
        return (s == IBUSY) || (s == DBUSY);
    endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// rtl/arb_timeout_counter.sv - clear/enable counter flagging the last allowed busy cycle
module arb_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // Holds at the terminal value; the owner leaves BUSY and clears it next cycle.
    always_ff @(posedge clk_i) begin
        if (!rstn_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !tc_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - single-port RAM arbiter, data priority with instruction starvation guard
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    input  ramstate_t         ramstate,
    input  logic [WORD_W-1:0] ramload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              dhit,
    output logic [WORD_W-1:0] dmemload,
    output logic              bus_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_t        state_q;
    logic [SW-1:0]     starve_q;
    logic              ramREN_q, ramWEN_q, ihit_q, dhit_q, bus_err_q;
    logic [WORD_W-1:0] ramaddr_q, ramstore_q, imemload_q, dmemload_q;

    logic d_req_d, d_win_d, own_req_d, tmo_tc;

    assign d_req_d   = dmemREN | dmemWEN;
    assign d_win_d   = d_req_d && (!imemREN || (starve_q < STARVE_LIM));
    assign own_req_d = (state_q == IBUSY) ? imemREN : d_req_d;

    arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_i  (CLK),
        .rstn_i (nRST),
        .clr_i  (!is_busy(state_q)),
        .en_i   (is_busy(state_q)),
        .tc_o   (tmo_tc)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            ramREN_q   <= 1'b0;
            ramWEN_q   <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
            ihit_q     <= 1'b0;
            dhit_q     <= 1'b0;
            imemload_q <= '0;
            dmemload_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            ihit_q <= 1'b0;
            dhit_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_win_d) begin
                        state_q    <= DBUSY;
                        ramaddr_q  <= dmemaddr;
                        ramstore_q <= dmemstore;
                        ramREN_q   <= dmemREN;
                        ramWEN_q   <= dmemWEN;
                        if (imemREN && (starve_q < STARVE_LIM)) begin
                            starve_q <= starve_q + 1'b1;
                        end
                    end else if (imemREN) begin
                        state_q   <= IBUSY;
                        ramaddr_q <= imemaddr;
                        ramREN_q  <= 1'b1;
                        ramWEN_q  <= 1'b0;
                        starve_q  <= '0;
                    end
                end
                IBUSY, DBUSY: begin
                    if (ramstate == ACCESS) begin
                        ramREN_q <= 1'b0;
                        ramWEN_q <= 1'b0;
                        if (state_q == IBUSY) begin
                            state_q    <= IHIT;
                            ihit_q     <= 1'b1;
                            imemload_q <= ramload;
                        end else begin
                            state_q <= DHIT;
                            dhit_q  <= 1'b1;
                            if (ramREN_q) begin
                                dmemload_q <= ramload;
                            end
                        end
                    end else if (ramstate == ERROR) begin
                        state_q   <= IDLE;
                        bus_err_q <= 1'b1;
                        ramREN_q  <= 1'b0;
                        ramWEN_q  <= 1'b0;
                    end else if (!own_req_d) begin
                        // Abandoned request: release the RAM quietly, no hit, no error.
                        state_q  <= IDLE;
                        ramREN_q <= 1'b0;
                        ramWEN_q <= 1'b0;
                    end else if (tmo_tc) begin
                        state_q   <= IDLE;
                        bus_err_q <= 1'b1;
                        ramREN_q  <= 1'b0;
                        ramWEN_q  <= 1'b0;
                    end
                end
                IHIT, DHIT: state_q <= IDLE;
                default:    state_q <= IDLE;
            endcase
        end
    end

    assign ramREN   = ramREN_q;
    assign ramWEN   = ramWEN_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;
    assign ihit     = ihit_q;
    assign imemload = imemload_q;
    assign dhit     = dhit_q;
    assign dmemload = dmemload_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed and randomized bench for memory_arbiter against a transaction model
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 64;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN, dmemREN, dmemWEN;
    logic [31:0] imemaddr, dmemaddr, dmemstore, ramload;
    ramstate_t   ramstate;
    logic        ramREN, ramWEN, ihit, dhit, bus_err;
    logic [31:0] ramaddr, ramstore, imemload, dmemload;

    memory_arbiter #(.WORD_W(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .ramstate(ramstate), .ramload(ramload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
        .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the RAM, who is being acknowledged, how long we waited.
    int          m_owner = 0;   // 0 none, 1 instruction, 2 data
    int          m_hit   = 0;   // 0 none, 1 ihit cycle, 2 dhit cycle
    int          m_wait  = 0;
    int          m_starve = 0;
    logic        m_ren = 0, m_wen = 0, m_err = 0, m_ihit = 0, m_dhit = 0, m_rd = 0;
    logic [31:0] m_addr = 0, m_store = 0, m_iload = 0, m_dload = 0;

    function automatic arb_state_t m_state();
        if (m_hit == 1)   return IHIT;
        if (m_hit == 2)   return DHIT;
        if (m_owner == 1) return IBUSY;
        if (m_owner == 2) return DBUSY;
        return IDLE;
    endfunction

    task automatic release_ram();
        m_owner = 0; m_ren = 0; m_wen = 0;
    endtask

    always @(posedge CLK) begin
        bit still;
        if (!nRST) begin
            m_owner = 0; m_hit = 0; m_wait = 0; m_starve = 0;
            m_ren = 0; m_wen = 0; m_err = 0; m_ihit = 0; m_dhit = 0; m_rd = 0;
            m_addr = 0; m_store = 0; m_iload = 0; m_dload = 0;
        end else if (m_hit != 0) begin
            m_hit = 0; m_ihit = 0; m_dhit = 0;
        end else if (m_owner == 0) begin
            if ((dmemREN || dmemWEN) && (!imemREN || m_starve < STARVE_MAX)) begin
                m_owner = 2; m_wait = 0;
                m_addr = dmemaddr; m_store = dmemstore; m_ren = dmemREN; m_wen = dmemWEN;
                if (imemREN) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
            end else if (imemREN) begin
                m_owner = 1; m_wait = 0; m_addr = imemaddr; m_ren = 1; m_wen = 0; m_starve = 0;
            end
        end else begin
            still = (m_owner == 1) ? imemREN : (dmemREN || dmemWEN);
            if (ramstate == ACCESS) begin
                if (m_owner == 1) begin
                    m_iload = ramload; m_hit = 1; m_ihit = 1;
                end else begin
                    m_rd = m_ren;
                    if (m_ren) m_dload = ramload;
                    m_hit = 2; m_dhit = 1;
                end
                release_ram();
            end else if (ramstate == ERROR) begin
                m_err = 1; release_ram();
            end else if (!still) begin
                release_ram();
            end else if (m_wait == TIMEOUT - 1) begin
                m_err = 1; release_ram();
            end else begin
                m_wait++;
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("m_state", 32'(dut.state_q), 32'(m_state()));
            chk("m_ramREN", 32'(ramREN), 32'(m_ren));
            chk("m_ramWEN", 32'(ramWEN), 32'(m_wen));
            chk("m_ihit", 32'(ihit), 32'(m_ihit));
            chk("m_dhit", 32'(dhit), 32'(m_dhit));
            chk("m_bus_err", 32'(bus_err), 32'(m_err));
            if (m_ren || m_wen) chk("m_ramaddr", ramaddr, m_addr);
            if (m_wen)          chk("m_ramstore", ramstore, m_store);
            if (m_ihit)         chk("m_imemload", imemload, m_iload);
            if (m_dhit && m_rd) chk("m_dmemload", dmemload, m_dload);
        end
    end

    task automatic cyc();
        @(negedge CLK);
    endtask

    initial begin
        int n;
        nRST = 0; imemREN = 0; dmemREN = 0; dmemWEN = 0;
        imemaddr = 0; dmemaddr = 0; dmemstore = 0; ramload = 0; ramstate = FREE;
        cyc();
        cmp_en = 1;

        // Reset while a data request is pending
        dmemREN = 1; dmemaddr = 32'h200;
        cyc(); cyc();
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_outs", {26'd0, ramREN, ramWEN, ihit, dhit, bus_err, 1'b0}, 32'd0);
        chk("rst_addr", ramaddr | ramstore | imemload | dmemload, 32'd0);
        nRST = 1;
        cyc();
        chk("rel_state", 32'(dut.state_q), 32'(DBUSY));
        chk("rel_addr", ramaddr, 32'h200);
        dmemREN = 0;
        cyc();

        // Instruction fetch
        imemREN = 1; imemaddr = 32'h40;
        cyc();
        chk("if_ren", 32'(ramREN), 32'd1);
        chk("if_addr", ramaddr, 32'h40);
        ramstate = BUSY;
        cyc();
        ramstate = ACCESS; ramload = 32'h8C220004;
        cyc();
        chk("if_ihit", 32'(ihit), 32'd1);
        chk("if_load", imemload, 32'h8C220004);
        chk("if_ren_low", 32'(ramREN), 32'd0);
        imemREN = 0; ramstate = FREE;
        cyc();
        chk("if_ihit_one", 32'(ihit), 32'd0);

        // Contention: data write beats the instruction
        imemREN = 1; imemaddr = 32'h80;
        dmemWEN = 1; dmemaddr = 32'h100; dmemstore = 32'hDEADBEEF;
        cyc();
        chk("ct_wen", 32'(ramWEN), 32'd1);
        chk("ct_store", ramstore, 32'hDEADBEEF);
        chk("ct_addr", ramaddr, 32'h100);
        ramstate = ACCESS;
        cyc();
        chk("ct_dhit", 32'(dhit), 32'd1);
        dmemWEN = 0; ramstate = FREE;
        cyc();
        cyc();
        chk("ct_ibusy", 32'(dut.state_q), 32'(IBUSY));
        chk("ct_iaddr", ramaddr, 32'h80);
        ramstate = ACCESS; ramload = 32'h1234_5678;
        cyc();
        chk("ct_ihit", 32'(ihit), 32'd1);
        imemREN = 0; ramstate = FREE;
        cyc();

        // Starvation guard: four data grants, then the waiting fetch
        imemREN = 1; imemaddr = 32'h300; dmemREN = 1; dmemaddr = 32'h400;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("sv_dbusy", 32'(dut.state_q), 32'(DBUSY));
            ramstate = ACCESS; ramload = 32'(i + 1);
            cyc();
            chk("sv_dhit", 32'(dhit), 32'd1);
            chk("sv_dload", dmemload, 32'(i + 1));
            ramstate = FREE; dmemaddr = dmemaddr + 4;
            cyc();
        end
        cyc();
        chk("sv_ibusy", 32'(dut.state_q), 32'(IBUSY));
        chk("sv_iaddr", ramaddr, 32'h300);
        ramstate = ACCESS;
        cyc();
        chk("sv_ihit", 32'(ihit), 32'd1);
        imemREN = 0; ramstate = FREE;
        cyc();
        cyc();
        chk("sv_fifth", 32'(dut.state_q), 32'(DBUSY));
        ramstate = ACCESS;
        cyc();
        dmemREN = 0; ramstate = FREE;
        cyc();

        // RAM error during a data access
        dmemREN = 1; dmemaddr = 32'h500;
        cyc();
        ramstate = ERROR;
        cyc();
        chk("er_state", 32'(dut.state_q), 32'(IDLE));
        chk("er_err", 32'(bus_err), 32'd1);
        chk("er_nohit", 32'(dhit), 32'd0);
        dmemREN = 0; ramstate = FREE;
        cyc(); cyc();
        chk("er_sticky", 32'(bus_err), 32'd1);
        nRST = 0; cyc(); nRST = 1;
        chk("er_clr", 32'(bus_err), 32'd0);

        // Timeout with RAM stuck at BUSY
        dmemREN = 1; dmemaddr = 32'h600; ramstate = BUSY;
        cyc();
        n = 0;
        while (dut.state_q == DBUSY && n < 200) begin
            cyc();
            n++;
        end
        dmemREN = 0; ramstate = FREE;
        chk("to_cycles", 32'(n), 32'd64);
        chk("to_err", 32'(bus_err), 32'd1);
        chk("to_state", 32'(dut.state_q), 32'(IDLE));
        nRST = 0; cyc(); nRST = 1;

        // Requester abort
        dmemREN = 1; dmemaddr = 32'h700;
        cyc();
        chk("ab_dbusy", 32'(dut.state_q), 32'(DBUSY));
        dmemREN = 0; ramstate = BUSY;
        cyc();
        chk("ab_idle", 32'(dut.state_q), 32'(IDLE));
        chk("ab_ren", 32'(ramREN), 32'd0);
        ramstate = FREE;
        cyc();
        chk("ab_nohit", 32'(dhit), 32'd0);

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            int r;
            nRST = ($urandom_range(0, 399) != 0);
            if (imemREN) begin
                if (m_ihit || $urandom_range(0, 49) == 0) imemREN = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                imemREN = 1; imemaddr = $urandom & 32'hFFFF_FFFC;
            end
            if (dmemREN || dmemWEN) begin
                if (m_dhit || $urandom_range(0, 49) == 0) begin
                    dmemREN = 0; dmemWEN = 0;
                end
            end else if ($urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 1) == 0) dmemREN = 1; else dmemWEN = 1;
                dmemaddr = $urandom & 32'hFFFF_FFFC; dmemstore = $urandom;
            end
            if (m_ren || m_wen) begin
                r = $urandom_range(0, 99);
                ramstate = (r < 3) ? ERROR : (r < 45) ? ACCESS : BUSY;
            end else begin
                ramstate = FREE;
            end
            ramload = $urandom;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Sits directly downstream of the request unit.
- Consumes the imemREN/dmemREN/dmemWEN requests and returns the ihit/dhit completions that the request unit uses to generate pcEN.
- Arbitrates the instruction and data ports onto the single shared RAM port: one transaction at a time, data has priority, with a bounded starvation guard for instruction fetch, timeout detection and a sticky error flag.

Parameters:
- WORD_W, 32, address/data width (matches cpu_types_pkg word_t).
- STARVE_MAX, 4, consecutive data grants allowed while an instruction request waits.
- TIMEOUT, 64, cycles in a BUSY state without ACCESS before abort.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  synchronous active-low reset.
- imemREN  input  1  instruction read request, held until ihit.
- imemaddr  input  WORD_W  instruction address.
- dmemREN  input  1  data read request, held until dhit.
- dmemWEN  input  1  data write request, held until dhit; dmemREN and dmemWEN are never both high.
- dmemaddr  input  WORD_W  data address.
- dmemstore  input  WORD_W  write data.
- ramstate  input  2  RAM status ramstate_t: FREE, BUSY, ACCESS, ERROR.
- ramload  input  WORD_W  RAM read data.
- ramREN  output  1  RAM read strobe.
- ramWEN  output  1  RAM write strobe.
- ramaddr  output  WORD_W  RAM address.
- ramstore  output  WORD_W  RAM write data.
- ihit  output  1  one-cycle instruction completion.
- imemload  output  WORD_W  fetched instruction, valid while ihit=1.
- dhit  output  1  one-cycle data completion.
- dmemload  output  WORD_W  load data, valid while dhit=1 after a read.
- bus_err  output  1  sticky error flag.

Behaviour:
- State machine states: IDLE, IBUSY, DBUSY, IHIT, DHIT. All state, counters and outputs are registered.
- Reset (nRST=0 at CLK edge, including mid-transaction):
  - state=IDLE.
  - ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, imemload, dmemload, bus_err = 0.
  - starve counter and timeout counter = 0.
  - An in-flight transaction is dropped; no hit is ever issued for it.
- IDLE:
  - Data request pending and (no instruction request or starve < STARVE_MAX) -> DBUSY; latch dmemaddr/dmemstore into ramaddr/ramstore; set ramREN/ramWEN from dmemREN/dmemWEN.
  - Otherwise imemREN=1 -> IBUSY; latch imemaddr; ramREN=1.
  - Same-cycle instruction and data requests -> data wins unless starve == STARVE_MAX.
- IBUSY/DBUSY:
  - RAM strobes are held constant.
  - ramstate==ACCESS -> IHIT/DHIT; capture ramload into imemload/dmemload (capture on reads only); drop strobes.
  - ramstate==ERROR -> IDLE; bus_err=1; strobes drop; no hit.
  - Requester deasserts its request -> IDLE; strobes drop; no hit. RAM is not left strobed.
  - Timeout counter increments each cycle in BUSY. At TIMEOUT-1 without ACCESS -> IDLE; bus_err=1. Counter clears on leaving BUSY.
- IHIT/DHIT:
  - ihit or dhit is high for exactly this one cycle.
  - Next state is IDLE. Back-to-back grants therefore have a one-cycle gap, which lets the RAM return to FREE.
- Latency: request seen in IDLE at edge N; strobe visible after N; with RAM ACCESS on cycle N+k, the hit is visible after edge N+k+1.
- Starve counter:
  - +1 per data grant made while imemREN=1.
  - Cleared on any instruction grant.
  - Saturates at STARVE_MAX.
- bus_err is cleared only by reset.
- ramstore is meaningful only when ramWEN=1. It is still registered, never X.

Decomposition:
- ramstate_t and word_t stay in cpu_types_pkg.
- Add an arb_state_t enum (IDLE, IBUSY, DBUSY, IHIT, DHIT) to cpu_types_pkg so that benches can probe it.
- One sub-module is natural: arb_timeout_counter, a clear/enable/terminal-count counter parameterised by TIMEOUT.

Test Plan:
- Reset: nRST=0 for 2 cycles while dmemREN=1 -> all outputs 0 and state IDLE; after release, DBUSY on the next edge.
- Instruction fetch: imemREN=1, imemaddr=0x40, RAM returns ACCESS with ramload=0x8C220004 two cycles after ramREN -> ihit=1 for one cycle with imemload=0x8C220004; ramREN low during IHIT.
- Contention: imemREN=1 and dmemWEN=1 (daddr=0x100, store=0xDEADBEEF) together -> data served first (ramWEN=1, ramstore=0xDEADBEEF), dhit, then IBUSY, ihit.
- Starvation: imemREN held with 5 back-to-back data requests, STARVE_MAX=4 -> after the 4th dhit, the instruction is granted before the 5th data request.
- Error/timeout: ramstate=ERROR during DBUSY -> no dhit, bus_err=1 stays high. Separately, ramstate stuck at BUSY for 64 cycles -> return to IDLE, bus_err=1.
- Abort: dmemREN dropped while in DBUSY -> IDLE next edge, ramREN=0, dhit never asserted.
